// File: rtl/image_pkg.sv
// Shared types and constants for the image streaming blocks.
package image_pkg;

  localparam int PIXEL_W_DEF = 12;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_SOP = 2'd1,
    STREAM   = 2'd2
  } sel_state_t;

endpackage

// File: rtl/stream_frame_tracker.sv
// Follows sop/eop framing on accepted beats and flags frame starts, ends and
// framing violations as combinational pulses for the owning controller.
module stream_frame_tracker (
  input  logic clk,
  input  logic reset,
  input  logic valid,
  input  logic ready,
  input  logic sop,
  input  logic eop,
  output logic frame_start,
  output logic frame_end,
  output logic frame_err
);

  logic in_frame;
  logic accepted;

  assign accepted    = valid & ready;
  assign frame_start = accepted & sop;
  assign frame_end   = accepted & eop;

  // A sop inside a frame, or an eop with no open frame and no sop on the same beat.
  assign frame_err = accepted & ((sop & in_frame) | (eop & ~sop & ~in_frame));

  always_ff @(posedge clk) begin
    if (reset) begin
      in_frame <= 1'b0;
    end else if (accepted) begin
      if (eop) begin
        in_frame <= 1'b0;
      end else if (sop) begin
        in_frame <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_source_select.sv
// Frame-aligned selector: forwards FRAMES_PER_MODE whole frames from each source
// in turn, switching source only between frames.
//
// state    | meaning
// IDLE     | not forwarding, upstream drained, waiting for at_table
// WAIT_SOP | sequence running, waiting for the next sop of cur_src
// STREAM   | forwarding the current frame of cur_src
module frame_source_select
  import image_pkg::*;
#(
  parameter int                 PIXEL_W         = PIXEL_W_DEF,
  parameter int                 NUM_SRC         = 2,
  parameter int                 FRAMES_PER_MODE = 1,
  parameter logic [PIXEL_W-1:0] IDLE_VALUE      = '0,
  localparam int                SRC_W           = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_SRC*PIXEL_W-1:0] data_in,
  input  logic                       sop_in,
  input  logic                       eop_in,
  input  logic                       valid_in,
  output logic                       ready_out,
  output logic [PIXEL_W-1:0]         data_out,
  output logic                       sop_out,
  output logic                       eop_out,
  output logic                       valid_out,
  input  logic                       ready_in,
  input  logic                       at_table,
  input  logic                       abort,
  output logic                       busy,
  output logic [SRC_W-1:0]           cur_src,
  output logic                       done,
  output logic                       err
);

  localparam int               CNT_W    = (FRAMES_PER_MODE > 1) ? $clog2(FRAMES_PER_MODE) : 1;
  localparam logic [SRC_W-1:0] LAST_SRC = SRC_W'(NUM_SRC - 1);
  localparam logic [CNT_W-1:0] LAST_FRM = CNT_W'(FRAMES_PER_MODE - 1);

  sel_state_t       state, state_nxt;
  logic [SRC_W-1:0] src_nxt;
  logic [CNT_W-1:0] frame_cnt, cnt_nxt;
  logic             abort_pend, pend_nxt;
  logic             done_nxt;
  logic             close_req;
  logic             pass;
  logic             sop_acc, eop_acc, frame_err;
  logic [PIXEL_W-1:0] src_pix [NUM_SRC];

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_unpack
    assign src_pix[k] = data_in[k*PIXEL_W +: PIXEL_W];
  end

  // The sop beat in WAIT_SOP is forwarded in the same cycle, so the pass decision
  // looks at sop_in directly rather than waiting for the STREAM state.
  assign pass      = ~reset & ((state == STREAM) | ((state == WAIT_SOP) & sop_in));
  assign data_out  = pass ? src_pix[cur_src] : IDLE_VALUE;
  assign sop_out   = pass & sop_in;
  assign eop_out   = pass & eop_in;
  assign valid_out = pass & valid_in;
  assign ready_out = pass ? ready_in : 1'b1;
  assign busy      = (state != IDLE);

  stream_frame_tracker u_tracker (
    .clk         (clk),
    .reset       (reset),
    .valid       (valid_in),
    .ready       (ready_out),
    .sop         (sop_in),
    .eop         (eop_in),
    .frame_start (sop_acc),
    .frame_end   (eop_acc),
    .frame_err   (frame_err)
  );

  always_comb begin
    state_nxt = state;
    src_nxt   = cur_src;
    cnt_nxt   = frame_cnt;
    pend_nxt  = abort_pend;
    done_nxt  = 1'b0;
    close_req = 1'b0;

    case (state)
      IDLE: begin
        if (at_table) begin
          state_nxt = WAIT_SOP;
          src_nxt   = '0;
          cnt_nxt   = '0;
          pend_nxt  = 1'b0;
        end
      end
      WAIT_SOP: begin
        // An abort arriving with the accepted sop cannot cut the frame; it waits for eop.
        if (sop_acc) begin
          state_nxt = STREAM;
          pend_nxt  = abort;
          close_req = eop_in;
        end else if (abort) begin
          state_nxt = IDLE;
        end
      end
      STREAM: begin
        if (abort) begin
          pend_nxt = 1'b1;
        end
        close_req = eop_acc;
      end
      default: state_nxt = IDLE;
    endcase

    if (close_req) begin
      if ((cur_src == LAST_SRC) && (frame_cnt == LAST_FRM)) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pend_nxt  = 1'b0;
        done_nxt  = 1'b1;
      end else if (pend_nxt) begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
        pend_nxt  = 1'b0;
      end else if (frame_cnt != LAST_FRM) begin
        state_nxt = WAIT_SOP;
        cnt_nxt   = frame_cnt + 1'b1;
      end else begin
        state_nxt = WAIT_SOP;
        cnt_nxt   = '0;
        src_nxt   = cur_src + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur_src    <= '0;
      frame_cnt  <= '0;
      abort_pend <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nxt;
      cur_src    <= src_nxt;
      frame_cnt  <= cnt_nxt;
      abort_pend <= pend_nxt;
      done       <= done_nxt;
      err        <= frame_err;
    end
  end

endmodule

// File: tb/tb_frame_source_select.sv
// Directed bench for frame_source_select with three sources and two frames per source.
module tb_frame_source_select;

  localparam int PW = 12;
  localparam int NS = 3;
  localparam int FPM = 2;
  localparam logic [PW-1:0] IDLE_V = 12'hABC;

  logic clk = 1'b0;
  logic reset;
  logic [NS*PW-1:0] data_in;
  logic sop_in, eop_in, valid_in, ready_out;
  logic [PW-1:0] data_out;
  logic sop_out, eop_out, valid_out, ready_in;
  logic at_table, abort, busy, done, err;
  logic [1:0] cur_src;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  frame_source_select #(
    .PIXEL_W(PW), .NUM_SRC(NS), .FRAMES_PER_MODE(FPM), .IDLE_VALUE(IDLE_V)
  ) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .sop_in(sop_in), .eop_in(eop_in),
    .valid_in(valid_in), .ready_out(ready_out), .data_out(data_out), .sop_out(sop_out),
    .eop_out(eop_out), .valid_out(valid_out), .ready_in(ready_in), .at_table(at_table),
    .abort(abort), .busy(busy), .cur_src(cur_src), .done(done), .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One beat; exp_src < 0 means the beat must be drained, otherwise forwarded from exp_src.
  // Source k carries pixel ((k+1)<<8)|idx.
  task automatic beat(input bit v, input bit s, input bit e, input int idx,
                      input int exp_src, input bit bp);
    bit acc;
    int guard;
    acc = 1'b0;
    guard = 0;
    valid_in = v;
    sop_in = s;
    eop_in = e;
    data_in = {PW'(12'h300 | idx), PW'(12'h200 | idx), PW'(12'h100 | idx)};
    do begin
      ready_in = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      if (exp_src >= 0 && reset == 1'b0) begin
        chk("valid_out", valid_out, v);
        chk("sop_out", sop_out, s);
        chk("eop_out", eop_out, e);
        chk("data_out", data_out, ((exp_src + 1) << 8) | idx);
        chk("ready_out", ready_out, ready_in);
        chk("cur_src", cur_src, exp_src);
        acc = ready_in | ~v;
      end else begin
        chk("valid_out_idle", valid_out, 0);
        chk("data_out_idle", data_out, IDLE_V);
        chk("ready_out_idle", ready_out, 1);
        acc = 1'b1;
      end
      @(posedge clk);
      #1;
      at_table = 1'b0;
      abort = 1'b0;
      guard++;
    end while (!acc && guard < 64);
    chk("beat_accepted", acc, 1);
  endtask

  task automatic frame(input int len, input int exp_src, input bit bp);
    for (int i = 0; i < len; i++) begin
      beat(1'b1, i == 0, i == len - 1, i, exp_src, bp);
    end
  endtask

  task automatic idle_cycle();
    beat(1'b0, 1'b0, 1'b0, 0, -1, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    at_table = 1'b0;
    abort = 1'b0;
    ready_in = 1'b1;
    valid_in = 1'b1;
    sop_in = 1'b1;
    eop_in = 1'b0;
    data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_out", valid_out, 0);
    chk("rst_data_out", data_out, IDLE_V);
    chk("rst_ready_out", ready_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_cur_src", cur_src, 0);
    reset = 1'b0;
    valid_in = 1'b0;
    sop_in = 1'b0;

    // Start mid-frame: that frame is drained, sequence begins at the next sop.
    beat(1, 1, 0, 0, -1, 0);
    beat(1, 0, 0, 1, -1, 0);
    at_table = 1'b1;
    beat(1, 0, 0, 2, -1, 0);
    chk("start_busy", busy, 1);
    beat(1, 0, 1, 3, -1, 0);
    chk("midframe_eop_err", err, 0);
    frame(4, 0, 0);
    chk("src0_f1_cur_src", cur_src, 0);
    frame(1, 0, 0);
    chk("after_src0_cur_src", cur_src, 1);
    frame(4, 1, 0);
    frame(2, 1, 0);
    chk("after_src1_cur_src", cur_src, 2);
    frame(1, 2, 0);
    chk("src2_done_early", done, 0);
    frame(3, 2, 0);
    chk("seq_done", done, 1);
    chk("seq_busy", busy, 0);
    idle_cycle();
    chk("done_one_cycle", done, 0);
    frame(4, -1, 0);

    // Abort mid-frame of src0: frame completes, no done.
    at_table = 1'b1;
    idle_cycle();
    beat(1, 1, 0, 0, 0, 0);
    abort = 1'b1;
    beat(1, 0, 0, 1, 0, 0);
    chk("abort_still_busy", busy, 1);
    beat(1, 0, 1, 2, 0, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    frame(2, -1, 0);

    // Abort while waiting for sop.
    at_table = 1'b1;
    idle_cycle();
    chk("wait_busy", busy, 1);
    abort = 1'b1;
    idle_cycle();
    chk("wait_abort_busy", busy, 0);
    chk("wait_abort_done", done, 0);

    // sop without eop inside a frame, then reset mid-frame, then stray eop.
    at_table = 1'b1;
    idle_cycle();
    beat(1, 1, 0, 0, 0, 0);
    beat(1, 0, 0, 1, 0, 0);
    chk("no_err_yet", err, 0);
    beat(1, 1, 0, 0, 0, 0);
    chk("sop_err", err, 1);
    beat(1, 0, 0, 1, 0, 0);
    chk("sop_err_once", err, 0);
    beat(1, 0, 1, 2, 0, 0);
    chk("resync_cur_src", cur_src, 0);
    frame(2, 0, 0);
    chk("resync_next_src", cur_src, 1);
    beat(1, 1, 0, 0, 1, 0);
    beat(1, 0, 0, 1, 1, 0);
    reset = 1'b1;
    beat(1, 0, 0, 2, -1, 0);
    reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_cur_src", cur_src, 0);
    beat(1, 0, 1, 3, -1, 0);
    chk("stray_eop_err", err, 1);
    idle_cycle();
    chk("stray_eop_err_once", err, 0);

    // Full sequence under random backpressure.
    at_table = 1'b1;
    idle_cycle();
    frame(3, 0, 1);
    frame(3, 0, 1);
    frame(3, 1, 1);
    frame(1, 1, 1);
    frame(3, 2, 1);
    frame(2, 2, 1);
    chk("bp_done", done, 1);
    chk("bp_busy", busy, 0);
    frame(3, -1, 1);
    chk("bp_err", err, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/frame_source_select.md
# frame_source_select

Parametrised, frame-aligned stream selector placed between the camera/filter pixel streams and the image sender. On a start pulse it forwards whole frames from each of NUM_SRC aligned pixel sources in turn (e.g. source 0 = raw, source 1 = blurred), FRAMES_PER_MODE frames per source. It then returns to idle and pulses `done`. Source changes happen only on frame boundaries, so no frame is ever spliced.

## Interface
Parameters:
- PIXEL_W, 12, pixel data width
- NUM_SRC, 2, number of aligned input sources (≥1)
- FRAMES_PER_MODE, 1, complete frames forwarded per source (≥1)
- IDLE_VALUE, 0, value driven on `data_out` when not forwarding

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- data_in  in  NUM_SRC×PIXEL_W  packed source pixels, all sharing one handshake
- sop_in  in  1  start of packet, shared
- eop_in  in  1  end of packet, shared
- valid_in  in  1  beat valid, shared
- ready_out  out  1  ready to upstream
- data_out  out  PIXEL_W  selected pixel
- sop_out  out  1  forwarded sop
- eop_out  out  1  forwarded eop
- valid_out  out  1  forwarded valid
- ready_in  in  1  downstream ready
- at_table  in  1  start pulse; ignored while busy
- abort  in  1  stop request
- busy  out  1  high in any state other than IDLE
- cur_src  out  max(1,$clog2(NUM_SRC))  source currently selected
- done  out  1  one-cycle pulse on normal sequence completion
- err  out  1  one-cycle pulse on a framing error

## Operation
- Accepted beat: `valid_in & ready_out`.
- FSM states: IDLE, WAIT_SOP, STREAM.
- IDLE:
  - `at_table` → WAIT_SOP; cur_src=0, frame_cnt=0, abort_pend=0.
  - `abort` in IDLE has no effect.
- WAIT_SOP:
  - Accepted beat with `sop_in` → STREAM. That beat is forwarded in the same cycle.
  - `abort` → IDLE immediately. No `done`.
- STREAM:
  - Forward every beat.
  - Accepted `eop_in` beat closes the frame:
    - If frame_cnt<FRAMES_PER_MODE-1: frame_cnt++ and go to WAIT_SOP.
    - Otherwise frame_cnt=0 and:
      - If cur_src==NUM_SRC-1: → IDLE and pulse `done`.
      - Else if abort_pend: → IDLE, no `done`.
      - Else: cur_src++ and go to WAIT_SOP.
  - abort_pend set while in STREAM → IDLE at the end of the current frame, regardless of counters, no `done`.
- Pass condition = STREAM, or (WAIT_SOP & `sop_in`).
  - When passing: `data_out`=data_in[cur_src], sop/eop/valid mirror inputs, `ready_out`=`ready_in`.
  - When not passing: `valid_out`=`sop_out`=`eop_out`=0, `data_out`=IDLE_VALUE, `ready_out`=1. Upstream beats are drained, never stalled.
- Framing errors:
  - `sop_in` accepted in STREAM with no preceding eop: pulse `err`, treat it as the start of a new frame, counters unchanged.
  - Accepted `eop_in` outside a frame: pulse `err`, no state change.
- An accepted beat with `sop_in & eop_in` is a complete single-beat frame.
- `at_table` and `abort` in the same IDLE cycle: start wins. The abort is not latched.

## Timing
- Data path is combinational, zero latency. Control state is registered.
- Reset values: state IDLE, cur_src=0, frame_cnt=0, abort_pend=0, `busy`=0, `done`=0, `err`=0. Reset forces `valid_out`=0, `data_out`=IDLE_VALUE, `ready_out`=1.
- Reset mid-frame drops the frame immediately. The next frame must start from IDLE.
- Counter/FSM updates occur on the clock edge of the accepted eop beat. `cur_src` changes only between frames.
- `done` and `err` are registered and high for exactly one cycle, one cycle after the triggering beat.
- `ready_in` low holds the beat. State does not advance without acceptance.

## Structure
- Shared package `image_pkg`:
  - FSM state enum `sel_state_t`.
  - Default pixel width constant `PIXEL_W_DEF`=12.
- One sub-module, `stream_frame_tracker`:
  - Tracks the in-frame flag from accepted beats.
  - Outputs frame_start, frame_end and framing-error pulses.
  - The FSM and counters stay in the top.

## Test plan
- NUM_SRC=2, FRAMES_PER_MODE=1, 4×4 frames, `at_table` pulsed mid-frame → the current frame is not forwarded. The next frame comes from src0, then one from src1. `done` pulses once and `busy` falls.
- NUM_SRC=3, FRAMES_PER_MODE=2, src k data=k+1 → output shows 2 frames of 1, 2 of 2, 2 of 3, then IDLE_VALUE. `cur_src` changes only after eop.
- Random `ready_in` backpressure (50 %) → output beats match input beats exactly. No duplicates or drops while passing. `ready_out`=1 while idle.
- `abort` asserted mid-frame of src0 → frame completes, then IDLE, `done`=0. `abort` in WAIT_SOP → IDLE the next cycle.
- sop without eop in STREAM → `err` pulses once and the new frame is forwarded. Stray eop in IDLE → `err` pulses, no output.
- `reset` asserted mid-frame → the next cycle shows `valid_out`=0, `busy`=0, `cur_src`=0. Single-beat sop&eop frames are each counted as a full frame.
